// File: rtl/tcdm_bank_pkg.sv
// Shared types for the TCDM bank adapter: requester identity, response-pipe
// entry and the packed crossbar request word layout.
package tcdm_bank_pkg;

    localparam int unsigned PkgAddrWidth = 10;
    localparam int unsigned PkgDataWidth = 32;
    localparam int unsigned PkgBeWidth   = PkgDataWidth / 8;

    typedef enum logic {
        XBAR = 1'b0,
        EXT  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
    } pipe_entry_t;

    // Crossbar request word, MSB first: {wen, be, addr, wdata}
    typedef struct packed {
        logic                    wen;
        logic [PkgBeWidth-1:0]   be;
        logic [PkgAddrWidth-1:0] addr;
        logic [PkgDataWidth-1:0] wdata;
    } xbar_req_t;

endpackage

// File: rtl/tcdm_bank_adapter_varlat_if.sv
// SRAM bank command/response bus between the bank adapter (master) and the
// memory macro (slave).
interface tcdm_bank_adapter_varlat_if #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8
) ();

    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/tcdm_bank_resp_pipe.sv
// Fixed-latency tracker for in-flight bank accesses; the entry presented at
// the output lines up with the SRAM read data of the same access.
module tcdm_bank_resp_pipe
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned MemLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  pipe_entry_t in_i,
    output pipe_entry_t out_o
);

    pipe_entry_t [MemLatency-1:0] stage_d;
    pipe_entry_t [MemLatency-1:0] stage_q;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_i;
        for (int unsigned i = 1; i < MemLatency; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[MemLatency-1];

endmodule

// File: rtl/tcdm_bank_adapter_varlat.sv
// Bank-side adapter: arbitrates crossbar vs external port onto one SRAM bank
// and routes responses back. Define TCDM_BANK_WRITE_RESP_EN to acknowledge writes.
module tcdm_bank_adapter_varlat
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned AddrWidth   = 10,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned BeWidth     = DataWidth / 8,
    parameter int unsigned MemLatency  = 1,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    // crossbar target port
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic [BeWidth+AddrWidth+DataWidth:0] wdata_i,
    output logic                                 vld_o,
    output logic [DataWidth-1:0]                 rdata_o,
    // external (DMA) port
    input  logic                                 ext_req_i,
    output logic                                 ext_gnt_o,
    input  logic                                 ext_wen_i,
    input  logic [AddrWidth-1:0]                 ext_addr_i,
    input  logic [BeWidth-1:0]                   ext_be_i,
    input  logic [DataWidth-1:0]                 ext_wdata_i,
    output logic                                 ext_vld_o,
    output logic [DataWidth-1:0]                 ext_rdata_o,
    // SRAM bank
    tcdm_bank_adapter_varlat_if.master           mem
);

    localparam int unsigned StarveWidth = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(StarveLimit);

    logic                 xbar_wen;
    logic [BeWidth-1:0]   xbar_be;
    logic [AddrWidth-1:0] xbar_addr;
    logic [DataWidth-1:0] xbar_wdata;

    logic [StarveWidth-1:0] starve_d;
    logic [StarveWidth-1:0] starve_q;
    logic                   starve_force;

    pipe_entry_t pipe_in;
    pipe_entry_t pipe_out;
    logic        deliver_rd;
    logic        deliver;

    assign xbar_wen   = wdata_i[BeWidth+AddrWidth+DataWidth];
    assign xbar_be    = wdata_i[AddrWidth+DataWidth +: BeWidth];
    assign xbar_addr  = wdata_i[DataWidth +: AddrWidth];
    assign xbar_wdata = wdata_i[DataWidth-1:0];

    // External port wins unless the crossbar has already lost StarveLimit cycles
    always_comb begin
        starve_force = (starve_q == StarveMax);
        gnt_o        = req_i & (~ext_req_i | starve_force);
        ext_gnt_o    = ext_req_i & ~gnt_o;
        starve_d     = '0;
        if (req_i && !gnt_o) begin
            starve_d = starve_force ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        mem.req   = gnt_o | ext_gnt_o;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.be    = '0;
        mem.wdata = '0;
        pipe_in   = '0;
        if (gnt_o) begin
            mem.we         = xbar_wen;
            mem.addr       = xbar_addr;
            mem.be         = xbar_be;
            mem.wdata      = xbar_wdata;
            pipe_in.valid    = 1'b1;
            pipe_in.owner    = XBAR;
            pipe_in.is_write = xbar_wen;
        end else if (ext_gnt_o) begin
            mem.we         = ext_wen_i;
            mem.addr       = ext_addr_i;
            mem.be         = ext_be_i;
            mem.wdata      = ext_wdata_i;
            pipe_in.valid    = 1'b1;
            pipe_in.owner    = EXT;
            pipe_in.is_write = ext_wen_i;
        end
    end

    tcdm_bank_resp_pipe #(
        .MemLatency (MemLatency)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (pipe_in),
        .out_o (pipe_out)
    );

    // Write acknowledges carry no data; rdata is only forwarded for reads
    always_comb begin
        deliver_rd = pipe_out.valid & ~pipe_out.is_write;
`ifdef TCDM_BANK_WRITE_RESP_EN
        deliver    = pipe_out.valid;
`else
        deliver    = deliver_rd;
`endif
        vld_o       = deliver & (pipe_out.owner == XBAR);
        ext_vld_o   = deliver & (pipe_out.owner == EXT);
        rdata_o     = (deliver_rd && pipe_out.owner == XBAR) ? mem.rdata : '0;
        ext_rdata_o = (deliver_rd && pipe_out.owner == EXT)  ? mem.rdata : '0;
    end

endmodule

// File: tb/tb_tcdm_bank_adapter_varlat.sv
// Directed bench for tcdm_bank_adapter_varlat: instance A (MemLatency=2,
// StarveLimit=4) and instance B (MemLatency=1, StarveLimit=0) share stimulus.
module tb_tcdm_bank_adapter_varlat;
    import tcdm_bank_pkg::*;

`ifdef TCDM_BANK_WRITE_RESP_EN
    localparam logic WR = 1'b1;
`else
    localparam logic WR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    xbar_req_t   xreq;
    logic        ext_req;
    logic        ext_wen;
    logic [9:0]  ext_addr;
    logic [3:0]  ext_be;
    logic [31:0] ext_wdata;

    logic        a_gnt, a_vld, a_ext_gnt, a_ext_vld;
    logic [31:0] a_rdata, a_ext_rdata;
    logic        b_gnt, b_vld, b_ext_gnt, b_ext_vld;
    logic [31:0] b_rdata, b_ext_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tcdm_bank_adapter_varlat_if #(.AddrWidth(10), .DataWidth(32)) mem_a_if ();
    tcdm_bank_adapter_varlat_if #(.AddrWidth(10), .DataWidth(32)) mem_b_if ();

    tcdm_bank_adapter_varlat #(
        .AddrWidth(10), .DataWidth(32), .MemLatency(2), .StarveLimit(4)
    ) u_a (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(a_gnt), .wdata_i(xreq), .vld_o(a_vld), .rdata_o(a_rdata),
        .ext_req_i(ext_req), .ext_gnt_o(a_ext_gnt), .ext_wen_i(ext_wen), .ext_addr_i(ext_addr),
        .ext_be_i(ext_be), .ext_wdata_i(ext_wdata), .ext_vld_o(a_ext_vld), .ext_rdata_o(a_ext_rdata),
        .mem(mem_a_if)
    );

    tcdm_bank_adapter_varlat #(
        .AddrWidth(10), .DataWidth(32), .MemLatency(1), .StarveLimit(0)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(b_gnt), .wdata_i(xreq), .vld_o(b_vld), .rdata_o(b_rdata),
        .ext_req_i(ext_req), .ext_gnt_o(b_ext_gnt), .ext_wen_i(ext_wen), .ext_addr_i(ext_addr),
        .ext_be_i(ext_be), .ext_wdata_i(ext_wdata), .ext_vld_o(b_ext_vld), .ext_rdata_o(b_ext_rdata),
        .mem(mem_b_if)
    );

    // Behavioural SRAM for A: two-cycle read latency, byte-enabled writes
    logic [31:0] sram_a [1024];
    logic [31:0] rd_a0, rd_a1;
    always @(posedge clk) begin
        if (mem_a_if.req && mem_a_if.we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_a_if.be[b]) sram_a[mem_a_if.addr][8*b +: 8] <= mem_a_if.wdata[8*b +: 8];
            end
        end
        rd_a0 <= (mem_a_if.req && !mem_a_if.we) ? sram_a[mem_a_if.addr] : 32'h0;
        rd_a1 <= rd_a0;
    end
    assign mem_a_if.rdata = rd_a1;

    // Behavioural SRAM for B: one-cycle read latency
    logic [31:0] sram_b [1024];
    logic [31:0] rd_b0;
    always @(posedge clk) begin
        if (mem_b_if.req && mem_b_if.we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_b_if.be[b]) sram_b[mem_b_if.addr][8*b +: 8] <= mem_b_if.wdata[8*b +: 8];
            end
        end
        rd_b0 <= (mem_b_if.req && !mem_b_if.we) ? sram_b[mem_b_if.addr] : 32'h0;
    end
    assign mem_b_if.rdata = rd_b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req       = 1'b0;
        xreq      = '0;
        ext_req   = 1'b0;
        ext_wen   = 1'b0;
        ext_addr  = '0;
        ext_be    = '0;
        ext_wdata = '0;
    endtask

    task automatic xbar(input logic wen, input logic [3:0] be, input logic [9:0] a, input logic [31:0] d);
        req        = 1'b1;
        xreq.wen   = wen;
        xreq.be    = be;
        xreq.addr  = a;
        xreq.wdata = d;
    endtask

    task automatic ext(input logic wen, input logic [3:0] be, input logic [9:0] a, input logic [31:0] d);
        ext_req   = 1'b1;
        ext_wen   = wen;
        ext_be    = be;
        ext_addr  = a;
        ext_wdata = d;
    endtask

    initial begin
        logic exp_x;
        rst = 1'b1;
        idle();
        step();
        step();
        check1 ("rst_a_vld",       a_vld, 1'b0);
        check1 ("rst_a_ext_vld",   a_ext_vld, 1'b0);
        check32("rst_a_rdata",     a_rdata, 32'h0);
        check32("rst_a_ext_rdata", a_ext_rdata, 32'h0);
        check1 ("rst_b_vld",       b_vld, 1'b0);
        check1 ("rst_a_mem_req",   mem_a_if.req, 1'b0);
        rst = 1'b0;

        // ext writes preload the bank
        ext(1'b1, 4'hF, 10'h010, 32'hDEADBEEF);
        #1;
        check1 ("ext_wr_gnt",      a_ext_gnt, 1'b1);
        check1 ("ext_wr_xbar_gnt", a_gnt, 1'b0);
        check1 ("ext_wr_mem_we",   mem_a_if.we, 1'b1);
        check32("ext_wr_mem_addr", 32'(mem_a_if.addr), 32'h010);
        check32("ext_wr_mem_wd",   mem_a_if.wdata, 32'hDEADBEEF);
        step();
        ext(1'b1, 4'hF, 10'h020, 32'h11223344);
        step();

        // crossbar partial write
        idle();
        xbar(1'b1, 4'b0011, 10'h020, 32'hAABBCCDD);
        #1;
        check1 ("xw_gnt",       a_gnt, 1'b1);
        check1 ("xw_ext_gnt",   a_ext_gnt, 1'b0);
        check1 ("xw_mem_we",    mem_a_if.we, 1'b1);
        check32("xw_mem_be",    32'(mem_a_if.be), 32'h3);
        check32("xw_mem_wdata", mem_a_if.wdata, 32'hAABBCCDD);
        check1 ("ext_wr0_resp", a_ext_vld, WR);
        check32("ext_wr0_rdata", a_ext_rdata, 32'h0);
        step();

        // crossbar read of 0x010
        xbar(1'b0, 4'h0, 10'h010, 32'h0);
        #1;
        check1 ("xr_gnt",       a_gnt, 1'b1);
        check1 ("xr_mem_we",    mem_a_if.we, 1'b0);
        check32("xr_mem_addr",  32'(mem_a_if.addr), 32'h010);
        check1 ("ext_wr1_resp", a_ext_vld, WR);
        step();
        idle();
        #1;
        check1 ("xw_resp",       a_vld, WR);
        check32("xw_resp_rdata", a_rdata, 32'h0);
        check1 ("idle_mem_req",  mem_a_if.req, 1'b0);
        check32("idle_mem_addr", 32'(mem_a_if.addr), 32'h0);
        step();
        check1 ("xr_vld",       a_vld, 1'b1);
        check32("xr_rdata",     a_rdata, 32'hDEADBEEF);
        check1 ("xr_ext_vld",   a_ext_vld, 1'b0);
        step();

        // read back merged bytes at 0x020
        xbar(1'b0, 4'h0, 10'h020, 32'h0);
        step();
        idle();
        #1;
        check1 ("xr2_gap", a_vld, 1'b0);
        step();
        check1 ("xr2_vld",   a_vld, 1'b1);
        check32("xr2_rdata", a_rdata, 32'h1122CCDD);
        step();

        // both request: A grants ext 4x then crossbar; B always grants crossbar
        for (int k = 0; k < 12; k++) begin
            idle();
            if (k < 10) begin
                xbar(1'b0, 4'h0, 10'h010, 32'h0);
                ext(1'b0, 4'h0, 10'h020, 32'h0);
            end
            #1;
            if (k < 10) begin
                check1($sformatf("stv_gnt_%0d", k),       a_gnt, (k % 5) == 4);
                check1($sformatf("stv_ext_gnt_%0d", k),   a_ext_gnt, (k % 5) != 4);
                check1($sformatf("stv0_gnt_%0d", k),      b_gnt, 1'b1);
                check1($sformatf("stv0_ext_gnt_%0d", k),  b_ext_gnt, 1'b0);
            end
            if (k >= 2) begin
                exp_x = ((k - 2) % 5) == 4;
                check1 ($sformatf("stv_vld_%0d", k),       a_vld, exp_x);
                check1 ($sformatf("stv_ext_vld_%0d", k),   a_ext_vld, !exp_x);
                check32($sformatf("stv_rdata_%0d", k),     a_rdata, exp_x ? 32'hDEADBEEF : 32'h0);
                check32($sformatf("stv_ext_rdata_%0d", k), a_ext_rdata, exp_x ? 32'h0 : 32'h1122CCDD);
            end
            step();
        end

        // alternating owners at full rate
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k < 6) begin
                if ((k % 2) == 0) xbar(1'b0, 4'h0, 10'h010, 32'h0);
                else              ext(1'b0, 4'h0, 10'h020, 32'h0);
            end
            #1;
            if (k >= 2) begin
                exp_x = ((k - 2) % 2) == 0;
                check1 ($sformatf("alt_vld_%0d", k),       a_vld, exp_x);
                check1 ($sformatf("alt_ext_vld_%0d", k),   a_ext_vld, !exp_x);
                check32($sformatf("alt_rdata_%0d", k),     a_rdata, exp_x ? 32'hDEADBEEF : 32'h0);
                check32($sformatf("alt_ext_rdata_%0d", k), a_ext_rdata, exp_x ? 32'h0 : 32'h1122CCDD);
            end
            step();
        end

        // reset with two reads in flight
        idle();
        xbar(1'b0, 4'h0, 10'h010, 32'h0);
        step();
        idle();
        ext(1'b0, 4'h0, 10'h020, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        check1 ("prst_a_vld",       a_vld, 1'b0);
        check1 ("prst_a_ext_vld",   a_ext_vld, 1'b0);
        check32("prst_a_rdata",     a_rdata, 32'h0);
        check32("prst_a_ext_rdata", a_ext_rdata, 32'h0);
        check1 ("prst_b_vld",       b_vld, 1'b0);
        check1 ("prst_b_ext_vld",   b_ext_vld, 1'b0);
        check32("prst_b_ext_rdata", b_ext_rdata, 32'h0);
        step();
        check1 ("prst2_a_vld",     a_vld, 1'b0);
        check1 ("prst2_a_ext_vld", a_ext_vld, 1'b0);
        check32("prst2_a_ext_rdata", a_ext_rdata, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
